// File: rtl/mips_multicycle_ctrl_pkg.sv
// mips_multicycle_ctrl_pkg: FSM states, instruction classes, opcode/funct, ALU and mux encodings
package mips_multicycle_ctrl_pkg;
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_e;
  typedef enum logic [3:0] {C_ILL, C_RALU, C_IALU, C_LOAD, C_STORE, C_BRANCH, C_J, C_JAL, C_JR, C_JALR} cls_e;
  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04, OP_BNE = 6'h05,
    OP_BLEZ = 6'h06, OP_BGTZ = 6'h07, OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0a,
    OP_SLTIU = 6'h0b, OP_ANDI = 6'h0c, OP_ORI = 6'h0d, OP_XORI = 6'h0e, OP_LUI = 6'h0f,
    OP_LB = 6'h20, OP_LW = 6'h23, OP_LBU = 6'h24, OP_SB = 6'h28, OP_SW = 6'h2b;
  localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_SRA = 6'h03, FN_SLLV = 6'h04,
    FN_SRLV = 6'h06, FN_SRAV = 6'h07, FN_JR = 6'h08, FN_JALR = 6'h09, FN_ADD = 6'h20,
    FN_ADDU = 6'h21, FN_SUB = 6'h22, FN_SUBU = 6'h23, FN_AND = 6'h24, FN_OR = 6'h25,
    FN_XOR = 6'h26, FN_NOR = 6'h27, FN_SLT = 6'h2a, FN_SLTU = 6'h2b;
  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3,
    ALU_XOR = 4'd4, ALU_NOR = 4'd5, ALU_SLT = 4'd6, ALU_SLTU = 4'd7, ALU_SLL = 4'd8,
    ALU_SRL = 4'd9, ALU_SRA = 4'd10, ALU_LUI = 4'd11;
  localparam logic [1:0] PC_ALU = 2'd0, PC_ALUOUT = 2'd1, PC_JUMP = 2'd2, PC_RS = 2'd3;
  localparam logic [1:0] RD_RT = 2'd0, RD_RD = 2'd1, RD_R31 = 2'd2;
  localparam logic [1:0] MR_ALU = 2'd0, MR_MDR = 2'd1, MR_PC = 2'd2;
  localparam logic [1:0] SB_RT = 2'd0, SB_FOUR = 2'd1, SB_IMM = 2'd2, SB_IMM_SH = 2'd3;
  localparam logic [1:0] ERR_NONE = 2'd0, ERR_ILLEGAL = 2'd1, ERR_TIMEOUT = 2'd2;
endpackage

// File: rtl/mips_multicycle_ctrl_decode.sv
// mips_multicycle_ctrl_decode: combinational opcode/funct decode into class and ALU controls
module mips_multicycle_ctrl_decode
  import mips_multicycle_ctrl_pkg::*;
#(
  parameter bit HAS_BYTE = 1'b1
) (
  input  logic [31:0] ins_i,
  output cls_e        cls_o,
  output logic [3:0]  alu_ctr_o,
  output logic        ext_op_o,
  output logic        useshamt_o,
  output logic        byte_o,
  output logic        sig_ctr_o,
  output logic        legal_o
);
  logic [5:0] op, fn;
  logic unused_ins;
  assign op = ins_i[31:26];
  assign fn = ins_i[5:0];
  assign unused_ins = ^ins_i[25:6];
  assign legal_o = cls_o != C_ILL;
  always_comb begin
    cls_o = C_ILL;
    alu_ctr_o = ALU_ADD;
    ext_op_o = 1'b1;
    useshamt_o = 1'b0;
    byte_o = 1'b0;
    sig_ctr_o = 1'b0;
    case (op)
      OP_R: begin
        cls_o = C_RALU;
        case (fn)
          FN_SLL: begin alu_ctr_o = ALU_SLL; useshamt_o = 1'b1; end
          FN_SRL: begin alu_ctr_o = ALU_SRL; useshamt_o = 1'b1; end
          FN_SRA: begin alu_ctr_o = ALU_SRA; useshamt_o = 1'b1; end
          FN_SLLV: alu_ctr_o = ALU_SLL;
          FN_SRLV: alu_ctr_o = ALU_SRL;
          FN_SRAV: alu_ctr_o = ALU_SRA;
          FN_JR: cls_o = C_JR;
          FN_JALR: cls_o = C_JALR;
          FN_ADD, FN_ADDU: alu_ctr_o = ALU_ADD;
          FN_SUB, FN_SUBU: alu_ctr_o = ALU_SUB;
          FN_AND: alu_ctr_o = ALU_AND;
          FN_OR: alu_ctr_o = ALU_OR;
          FN_XOR: alu_ctr_o = ALU_XOR;
          FN_NOR: alu_ctr_o = ALU_NOR;
          FN_SLT: alu_ctr_o = ALU_SLT;
          FN_SLTU: alu_ctr_o = ALU_SLTU;
          default: cls_o = C_ILL;
        endcase
      end
      OP_J: cls_o = C_J;
      OP_JAL: cls_o = C_JAL;
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin cls_o = C_BRANCH; alu_ctr_o = ALU_SUB; end
      OP_ADDI, OP_ADDIU: cls_o = C_IALU;
      OP_SLTI: begin cls_o = C_IALU; alu_ctr_o = ALU_SLT; end
      OP_SLTIU: begin cls_o = C_IALU; alu_ctr_o = ALU_SLTU; end
      OP_ANDI: begin cls_o = C_IALU; alu_ctr_o = ALU_AND; ext_op_o = 1'b0; end
      OP_ORI: begin cls_o = C_IALU; alu_ctr_o = ALU_OR; ext_op_o = 1'b0; end
      OP_XORI: begin cls_o = C_IALU; alu_ctr_o = ALU_XOR; ext_op_o = 1'b0; end
      OP_LUI: begin cls_o = C_IALU; alu_ctr_o = ALU_LUI; ext_op_o = 1'b0; end
      OP_LW: cls_o = C_LOAD;
      OP_SW: cls_o = C_STORE;
      OP_LB: begin
        if (HAS_BYTE) cls_o = C_LOAD;
        byte_o = 1'b1;
        sig_ctr_o = 1'b1;
      end
      OP_LBU: begin
        if (HAS_BYTE) cls_o = C_LOAD;
        byte_o = 1'b1;
      end
      OP_SB: begin
        if (HAS_BYTE) cls_o = C_STORE;
        byte_o = 1'b1;
      end
      default: cls_o = C_ILL;
    endcase
  end
endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multi-cycle MIPS control FSM with memory wait timeout and sticky error
module mips_multicycle_ctrl
  import mips_multicycle_ctrl_pkg::*;
#(
  parameter int ALUCTR_W    = 4,
  parameter int MEM_TIMEOUT = 16,
  parameter bit HAS_BYTE    = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [31:0]         ins_i,
  input  logic                zero_i,
  input  logic                negative_i,
  input  logic                mem_ready_i,
  output logic                mem_req_o,
  output logic                mem_wr_o,
  output logic                byte_o,
  output logic                sig_ctr_o,
  output logic                iord_o,
  output logic                ir_wr_o,
  output logic                pc_wr_o,
  output logic [1:0]          pc_src_o,
  output logic                reg_wr_o,
  output logic [1:0]          reg_dst_o,
  output logic [1:0]          mem_to_reg_o,
  output logic                alu_src_a_o,
  output logic [1:0]          alu_src_b_o,
  output logic                ext_op_o,
  output logic                useshamt_o,
  output logic [ALUCTR_W-1:0] alu_ctr_o,
  output logic                retire_o,
  output logic                halted_o,
  output logic [1:0]          err_code_o
);
  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0] err_q, err_d;
  cls_e cls;
  logic [3:0] dec_alu;
  logic dec_ext, dec_sh, dec_byte, dec_sig, legal;
  logic jump, reg_jump, link, mem_op, imm_op, taken;
  mips_multicycle_ctrl_decode #(.HAS_BYTE(HAS_BYTE)) u_dec (
    .ins_i(ins_i), .cls_o(cls), .alu_ctr_o(dec_alu), .ext_op_o(dec_ext), .useshamt_o(dec_sh),
    .byte_o(dec_byte), .sig_ctr_o(dec_sig), .legal_o(legal)
  );
  assign reg_jump = cls == C_JR || cls == C_JALR;
  assign link = cls == C_JAL || cls == C_JALR;
  assign jump = reg_jump || cls == C_J || cls == C_JAL;
  assign mem_op = cls == C_LOAD || cls == C_STORE;
  assign imm_op = mem_op || cls == C_IALU;
  // opcode bits [27:26] select beq/bne/blez/bgtz; bit 26 inverts the condition
  assign taken = ins_i[26] ^ (ins_i[27] ? (zero_i | negative_i) : zero_i);
  assign err_code_o = rst_ni ? err_q : ERR_NONE;
  always_comb begin
    state_d = state_q;
    cnt_d = '0;
    err_d = err_q;
    mem_req_o = 1'b0;
    mem_wr_o = 1'b0;
    byte_o = 1'b0;
    sig_ctr_o = 1'b0;
    iord_o = 1'b0;
    ir_wr_o = 1'b0;
    pc_wr_o = 1'b0;
    pc_src_o = PC_ALU;
    reg_wr_o = 1'b0;
    reg_dst_o = RD_RT;
    mem_to_reg_o = MR_ALU;
    alu_src_a_o = 1'b0;
    alu_src_b_o = SB_RT;
    ext_op_o = 1'b0;
    useshamt_o = 1'b0;
    alu_ctr_o = '0;
    retire_o = 1'b0;
    halted_o = 1'b0;
    if (rst_ni) begin
      case (state_q)
        S_FETCH: begin
          mem_req_o = 1'b1;
          alu_src_b_o = SB_FOUR;
          ir_wr_o = mem_ready_i;
          pc_wr_o = mem_ready_i;
          if (mem_ready_i) state_d = S_DECODE;
        end
        S_DECODE: begin
          alu_src_b_o = SB_IMM_SH;
          ext_op_o = 1'b1;
          if (!legal) begin
            err_d = ERR_ILLEGAL;
            state_d = S_HALT;
          end else if (jump) begin
            pc_wr_o = 1'b1;
            retire_o = 1'b1;
            pc_src_o = reg_jump ? PC_RS : PC_JUMP;
            reg_wr_o = link;
            reg_dst_o = cls == C_JAL ? RD_R31 : cls == C_JALR ? RD_RD : RD_RT;
            mem_to_reg_o = link ? MR_PC : MR_ALU;
            state_d = S_FETCH;
          end else state_d = S_EXEC;
        end
        S_EXEC: begin
          alu_src_a_o = 1'b1;
          alu_src_b_o = imm_op ? SB_IMM : SB_RT;
          ext_op_o = imm_op & dec_ext;
          useshamt_o = dec_sh;
          alu_ctr_o = ALUCTR_W'(dec_alu);
          if (cls == C_BRANCH) begin
            pc_wr_o = taken;
            pc_src_o = PC_ALUOUT;
            retire_o = 1'b1;
            state_d = S_FETCH;
          end else if (mem_op) state_d = S_MEM;
          else state_d = S_WB;
        end
        S_MEM: begin
          mem_req_o = 1'b1;
          iord_o = 1'b1;
          mem_wr_o = cls == C_STORE;
          byte_o = dec_byte;
          sig_ctr_o = dec_sig;
          if (mem_ready_i && cls == C_STORE) begin
            retire_o = 1'b1;
            state_d = S_FETCH;
          end else if (mem_ready_i) state_d = S_WB;
        end
        S_WB: begin
          reg_wr_o = 1'b1;
          retire_o = 1'b1;
          reg_dst_o = cls == C_RALU ? RD_RD : RD_RT;
          mem_to_reg_o = cls == C_LOAD ? MR_MDR : MR_ALU;
          state_d = S_FETCH;
        end
        S_HALT: halted_o = 1'b1;
        default: state_d = S_FETCH;
      endcase
      if (mem_req_o && !mem_ready_i) begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
          err_d = ERR_TIMEOUT;
          state_d = S_HALT;
        end
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_FETCH;
      cnt_q <= '0;
      err_q <= ERR_NONE;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: table-driven per-cycle checks plus timeout and byte-less build sequences
module tb_mips_multicycle_ctrl;
  typedef struct packed {
    logic mem_req, mem_wr, bt, sig_ctr, iord, ir_wr, pc_wr;
    logic [1:0] pc_src;
    logic reg_wr;
    logic [1:0] reg_dst, mem_to_reg;
    logic alu_src_a;
    logic [1:0] alu_src_b;
    logic ext_op, useshamt;
    logic [3:0] alu_ctr;
    logic retire, halted;
    logic [1:0] err;
  } out_t;
  typedef struct {
    logic rst_n;
    logic [31:0] ins;
    logic rdy, z, n;
    out_t exp;
    logic [1:0] nb;
  } vec_t;
  localparam logic [31:0] I_ADDU = 32'h00221821, I_LW = 32'h8C850008, I_BEQ = 32'h10220003,
    I_BNE = 32'h14220003, I_BLEZ = 32'h18200003, I_BGTZ = 32'h1C200003, I_JAL = 32'h0C000040,
    I_J = 32'h08000010, I_JR = 32'h03E00008, I_JALR = 32'h00201809, I_SW = 32'hACE60004,
    I_SLL = 32'h00031100, I_ORI = 32'h344100FF, I_LB = 32'h80410000, I_LBU = 32'h90410000,
    I_BAD = 32'hFC000000;
  logic clk = 1'b0, rst_n = 1'b0, zero = 1'b0, neg = 1'b0, rdy = 1'b0;
  logic [31:0] ins = '0;
  logic mem_req, mem_wr, bt, sig_ctr, iord, ir_wr, pc_wr, reg_wr, alu_src_a, ext_op, useshamt, retire, halted;
  logic [1:0] pc_src, reg_dst, mem_to_reg, alu_src_b, err_code;
  logic [3:0] alu_ctr;
  logic nb_mem_req, nb_mem_wr, nb_bt, nb_sig_ctr, nb_iord, nb_ir_wr, nb_pc_wr, nb_reg_wr;
  logic nb_alu_src_a, nb_ext_op, nb_useshamt, nb_retire, nb_halted;
  logic [1:0] nb_pc_src, nb_reg_dst, nb_mem_to_reg, nb_alu_src_b, nb_err;
  logic [3:0] nb_alu_ctr;
  out_t got;
  vec_t v[$];
  logic [1:0] nb_e;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  mips_multicycle_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n), .ins_i(ins), .zero_i(zero), .negative_i(neg), .mem_ready_i(rdy),
    .mem_req_o(mem_req), .mem_wr_o(mem_wr), .byte_o(bt), .sig_ctr_o(sig_ctr), .iord_o(iord),
    .ir_wr_o(ir_wr), .pc_wr_o(pc_wr), .pc_src_o(pc_src), .reg_wr_o(reg_wr), .reg_dst_o(reg_dst),
    .mem_to_reg_o(mem_to_reg), .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b), .ext_op_o(ext_op),
    .useshamt_o(useshamt), .alu_ctr_o(alu_ctr), .retire_o(retire), .halted_o(halted), .err_code_o(err_code)
  );
  mips_multicycle_ctrl #(.HAS_BYTE(1'b0)) dut_nb (
    .clk_i(clk), .rst_ni(rst_n), .ins_i(ins), .zero_i(zero), .negative_i(neg), .mem_ready_i(rdy),
    .mem_req_o(nb_mem_req), .mem_wr_o(nb_mem_wr), .byte_o(nb_bt), .sig_ctr_o(nb_sig_ctr), .iord_o(nb_iord),
    .ir_wr_o(nb_ir_wr), .pc_wr_o(nb_pc_wr), .pc_src_o(nb_pc_src), .reg_wr_o(nb_reg_wr), .reg_dst_o(nb_reg_dst),
    .mem_to_reg_o(nb_mem_to_reg), .alu_src_a_o(nb_alu_src_a), .alu_src_b_o(nb_alu_src_b), .ext_op_o(nb_ext_op),
    .useshamt_o(nb_useshamt), .alu_ctr_o(nb_alu_ctr), .retire_o(nb_retire), .halted_o(nb_halted), .err_code_o(nb_err)
  );
  assign got = {mem_req, mem_wr, bt, sig_ctr, iord, ir_wr, pc_wr, pc_src, reg_wr, reg_dst, mem_to_reg,
                alu_src_a, alu_src_b, ext_op, useshamt, alu_ctr, retire, halted, err_code};
  function automatic out_t fe(input logic r);
    out_t o = '0;
    o.mem_req = 1'b1; o.alu_src_b = 2'd1; o.ir_wr = r; o.pc_wr = r;
    return o;
  endfunction
  function automatic out_t de();
    out_t o = '0;
    o.alu_src_b = 2'd3; o.ext_op = 1'b1;
    return o;
  endfunction
  function automatic out_t dj(input logic [1:0] src, input logic rw, input logic [1:0] dst, input logic [1:0] m2r);
    out_t o = de();
    o.pc_wr = 1'b1; o.retire = 1'b1; o.pc_src = src; o.reg_wr = rw; o.reg_dst = dst; o.mem_to_reg = m2r;
    return o;
  endfunction
  function automatic out_t ex(input logic [1:0] sb, input logic ext, input logic [3:0] alu, input logic sh);
    out_t o = '0;
    o.alu_src_a = 1'b1; o.alu_src_b = sb; o.ext_op = ext; o.alu_ctr = alu; o.useshamt = sh;
    return o;
  endfunction
  function automatic out_t br(input logic t);
    out_t o = ex(2'd0, 1'b0, 4'd1, 1'b0);
    o.pc_wr = t; o.pc_src = 2'd1; o.retire = 1'b1;
    return o;
  endfunction
  function automatic out_t me(input logic r, input logic wr, input logic b, input logic s);
    out_t o = '0;
    o.mem_req = 1'b1; o.iord = 1'b1; o.mem_wr = wr; o.bt = b; o.sig_ctr = s; o.retire = r & wr;
    return o;
  endfunction
  function automatic out_t wb(input logic [1:0] dst, input logic [1:0] m2r);
    out_t o = '0;
    o.reg_wr = 1'b1; o.retire = 1'b1; o.reg_dst = dst; o.mem_to_reg = m2r;
    return o;
  endfunction
  function automatic out_t ht(input logic [1:0] e);
    out_t o = '0;
    o.halted = 1'b1; o.err = e;
    return o;
  endfunction
  task automatic push(input logic r, input logic [31:0] i, input logic rd, input logic z, input logic n, input out_t e);
    vec_t t;
    t.rst_n = r; t.ins = i; t.rdy = rd; t.z = z; t.n = n; t.exp = e; t.nb = nb_e;
    v.push_back(t);
  endtask
  task automatic a(input logic [31:0] i, input logic rd, input out_t e);
    push(1'b1, i, rd, 1'b0, 1'b0, e);
  endtask
  task automatic ab(input logic [31:0] i, input logic z, input logic n, input out_t e);
    push(1'b1, i, 1'b1, z, n, e);
  endtask
  task automatic ar(input logic rd);
    push(1'b0, I_ADDU, rd, 1'b0, 1'b0, '0);
  endtask
  task automatic chk(input string nm, input out_t g, input out_t e);
    total++;
    if (g !== e) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, g, e);
    end
  endtask
  task automatic chk_err(input string nm, input logic [1:0] g, input logic [1:0] e);
    total++;
    if (g !== e) begin
      bad++;
      $display("FAIL %s err_code got=%0d exp=%0d", nm, g, e);
    end
  endtask
  task automatic branch(input logic [31:0] i, input logic z, input logic n, input logic t);
    a(i, 1'b1, fe(1'b1)); a(i, 1'b1, de()); ab(i, z, n, br(t));
  endtask
  task automatic jmp(input logic [31:0] i, input out_t e);
    a(i, 1'b1, fe(1'b1)); a(i, 1'b1, e);
  endtask
  initial begin
    nb_e = 2'd0;
    ar(1'b1); ar(1'b1);
    a(I_ADDU, 1'b1, fe(1'b1)); a(I_ADDU, 1'b1, de()); a(I_ADDU, 1'b1, ex(2'd0, 1'b0, 4'd0, 1'b0));
    a(I_ADDU, 1'b1, wb(2'd1, 2'd0));
    a(I_LW, 1'b0, fe(1'b0)); a(I_LW, 1'b1, fe(1'b1)); a(I_LW, 1'b1, de());
    a(I_LW, 1'b1, ex(2'd2, 1'b1, 4'd0, 1'b0));
    for (int k = 0; k < 3; k++) a(I_LW, 1'b0, me(1'b0, 1'b0, 1'b0, 1'b0));
    a(I_LW, 1'b1, me(1'b1, 1'b0, 1'b0, 1'b0)); a(I_LW, 1'b1, wb(2'd0, 2'd1));
    branch(I_BEQ, 1'b1, 1'b0, 1'b1); branch(I_BEQ, 1'b0, 1'b0, 1'b0);
    branch(I_BNE, 1'b0, 1'b0, 1'b1); branch(I_BLEZ, 1'b0, 1'b1, 1'b1);
    branch(I_BGTZ, 1'b0, 1'b1, 1'b0); branch(I_BGTZ, 1'b0, 1'b0, 1'b1);
    jmp(I_JAL, dj(2'd2, 1'b1, 2'd2, 2'd2)); jmp(I_J, dj(2'd2, 1'b0, 2'd0, 2'd0));
    jmp(I_JR, dj(2'd3, 1'b0, 2'd0, 2'd0)); jmp(I_JALR, dj(2'd3, 1'b1, 2'd1, 2'd2));
    a(I_SW, 1'b1, fe(1'b1)); a(I_SW, 1'b1, de()); a(I_SW, 1'b1, ex(2'd2, 1'b1, 4'd0, 1'b0));
    a(I_SW, 1'b1, me(1'b1, 1'b1, 1'b0, 1'b0));
    a(I_SLL, 1'b1, fe(1'b1)); a(I_SLL, 1'b1, de()); a(I_SLL, 1'b1, ex(2'd0, 1'b0, 4'd8, 1'b1));
    a(I_SLL, 1'b1, wb(2'd1, 2'd0));
    a(I_ORI, 1'b1, fe(1'b1)); a(I_ORI, 1'b1, de()); a(I_ORI, 1'b1, ex(2'd2, 1'b0, 4'd3, 1'b0));
    a(I_ORI, 1'b1, wb(2'd0, 2'd0));
    a(I_LB, 1'b1, fe(1'b1)); a(I_LB, 1'b1, de());
    nb_e = 2'd1;
    a(I_LB, 1'b1, ex(2'd2, 1'b1, 4'd0, 1'b0)); a(I_LB, 1'b1, me(1'b1, 1'b0, 1'b1, 1'b1));
    a(I_LB, 1'b1, wb(2'd0, 2'd1));
    a(I_LBU, 1'b1, fe(1'b1)); a(I_LBU, 1'b1, de()); a(I_LBU, 1'b1, ex(2'd2, 1'b1, 4'd0, 1'b0));
    a(I_LBU, 1'b1, me(1'b1, 1'b0, 1'b1, 1'b0)); a(I_LBU, 1'b1, wb(2'd0, 2'd1));
    a(I_BAD, 1'b1, fe(1'b1)); a(I_BAD, 1'b1, de());
    a(I_BAD, 1'b1, ht(2'd1)); a(I_BAD, 1'b1, ht(2'd1)); a(I_BAD, 1'b0, ht(2'd1));
    nb_e = 2'd0;
    ar(1'b1);
    a(I_LW, 1'b1, fe(1'b1)); a(I_LW, 1'b1, de()); a(I_LW, 1'b1, ex(2'd2, 1'b1, 4'd0, 1'b0));
    a(I_LW, 1'b0, me(1'b0, 1'b0, 1'b0, 1'b0)); a(I_LW, 1'b0, me(1'b0, 1'b0, 1'b0, 1'b0));
    ar(1'b0);
    a(I_LW, 1'b0, fe(1'b0)); a(I_LW, 1'b1, fe(1'b1)); a(I_LW, 1'b1, de());
    for (int i = 0; i < v.size(); i++) begin
      @(negedge clk);
      rst_n = v[i].rst_n; ins = v[i].ins; rdy = v[i].rdy; zero = v[i].z; neg = v[i].n;
      #1;
      chk($sformatf("vec%0d", i), got, v[i].exp);
      chk_err($sformatf("nb%0d", i), nb_err, v[i].nb);
    end
    @(negedge clk);
    rst_n = 1'b0; rdy = 1'b0; ins = I_ADDU;
    #1 chk("tmo_rst", got, '0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (k > 0) @(negedge clk);
      #1 chk($sformatf("tmo_wait%0d", k + 1), got, fe(1'b0));
    end
    @(negedge clk);
    rdy = 1'b1;
    #1 chk("tmo_halt", got, ht(2'd2));
    chk_err("tmo_nb", nb_err, 2'd2);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1 chk($sformatf("tmo_stay%0d", k), got, ht(2'd2));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
